// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard receiver: filters and frames PS2_CLK/PS2_DAT, strips E0/F0 prefixes and
// turns each player's direction-key make/break codes into one-hot direction outputs.
module ps2_direction_rx #(
  parameter int NUM_PLAYERS    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit HOLD_MODE      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      PS2_CLK,
  input  logic                      PS2_DAT,
  input  logic [36*NUM_PLAYERS-1:0] keymap,
  output logic [7:0]                scan_code,
  output logic                      scan_valid,
  output logic                      scan_break,
  output logic                      scan_ext,
  output logic                      frame_err,
  output logic [NUM_PLAYERS-1:0]    dir_left,
  output logic [NUM_PLAYERS-1:0]    dir_right,
  output logic [NUM_PLAYERS-1:0]    dir_up,
  output logic [NUM_PLAYERS-1:0]    dir_down
);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic                         r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic                         r_filt_clk;
  logic [FCW-1:0]               r_filt_cnt;
  logic                         r_strobe, r_sdat;
  state_t                       r_state, w_state_nxt;
  logic [2:0]                   r_bit_cnt;
  logic [7:0]                   r_shift;
  logic                         r_parity_ok;
  logic [TCW-1:0]               r_to_cnt;
  logic                         w_timeout, w_stop_done, w_frame_ok, w_frame_bad;
  logic                         r_ext_flag, r_brk_flag;
  logic [NUM_PLAYERS-1:0]       w_hit;
  logic [NUM_PLAYERS-1:0][1:0]  w_key;
  logic [NUM_PLAYERS-1:0][3:0]  r_pressed;
  logic [NUM_PLAYERS-1:0][1:0]  r_last;
  logic [NUM_PLAYERS-1:0][3:0]  r_lat;
  logic [NUM_PLAYERS-1:0][3:0]  w_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_DAT;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock flips only after FILTER_LEN consecutive differing samples;
  // a flip to low is the bit-sample strobe, with data captured alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_strobe   <= 1'b0;
      r_sdat     <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
        r_strobe   <= ~r_clk_s2;
        r_sdat     <= r_dat_s2;
      end else begin
        r_filt_cnt <= r_filt_cnt + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:   if (r_strobe && !r_sdat) w_state_nxt = ST_DATA;
      ST_DATA:   if (r_strobe && r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
      ST_PARITY: if (r_strobe) w_state_nxt = ST_STOP;
      ST_STOP:   if (r_strobe) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && !r_strobe && r_to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
      w_timeout   = 1'b1;
      w_state_nxt = ST_IDLE;
    end
    w_stop_done = (r_state == ST_STOP) && r_strobe;
    w_frame_ok  = w_stop_done && r_sdat && r_parity_ok;
    w_frame_bad = (w_stop_done && !(r_sdat && r_parity_ok)) || w_timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity_ok <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_to_cnt <= (r_state == ST_IDLE || r_strobe) ? '0 : r_to_cnt + TCW'(1);
      if (r_strobe) begin
        case (r_state)
          ST_IDLE:   r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {r_sdat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_PARITY: r_parity_ok <= ^{r_shift, r_sdat};
          default:   r_bit_cnt <= r_bit_cnt;
        endcase
      end
    end
  end

  // Prefix bytes only arm flags; any other good byte is published with the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_valid <= 1'b0;
      scan_code  <= '0;
      scan_break <= 1'b0;
      scan_ext   <= 1'b0;
      frame_err  <= 1'b0;
      r_ext_flag <= 1'b0;
      r_brk_flag <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (w_frame_bad) begin
        frame_err  <= 1'b1;
        r_ext_flag <= 1'b0;
        r_brk_flag <= 1'b0;
      end else if (w_frame_ok) begin
        if (r_shift == 8'hE0) begin
          r_ext_flag <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_flag <= 1'b1;
        end else begin
          scan_valid <= 1'b1;
          scan_code  <= r_shift;
          scan_break <= r_brk_flag;
          scan_ext   <= r_ext_flag;
          r_ext_flag <= 1'b0;
          r_brk_flag <= 1'b0;
        end
      end
    end
  end

  // Descending scan so the lowest matching key index (LEFT first) wins.
  always_comb begin
    w_hit = '0;
    w_key = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int k = 3; k >= 0; k--) begin
        if ({scan_ext, scan_code} == keymap[36*p + 27 - 9*k +: 9]) begin
          w_hit[p] = 1'b1;
          w_key[p] = 2'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pressed <= '0;
      r_last    <= '0;
      r_lat     <= '0;
    end else if (scan_valid) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (w_hit[p]) begin
          if (scan_break) begin
            r_pressed[p][w_key[p]] <= 1'b0;
          end else begin
            r_pressed[p][w_key[p]] <= 1'b1;
            r_last[p]              <= w_key[p];
            r_lat[p]               <= 4'b0001 << w_key[p];
          end
        end
      end
    end
  end

  always_comb begin
    w_oh      = '0;
    dir_left  = '0;
    dir_right = '0;
    dir_up    = '0;
    dir_down  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (HOLD_MODE) w_oh[p] = r_pressed[p][r_last[p]] ? (4'b0001 << r_last[p]) : 4'b0000;
      else           w_oh[p] = r_lat[p];
      dir_left[p]  = w_oh[p][0];
      dir_right[p] = w_oh[p][1];
      dir_up[p]    = w_oh[p][2];
      dir_down[p]  = w_oh[p][3];
    end
  end

endmodule

// File: tb/tb_ps2_direction_rx.sv
// Bench for ps2_direction_rx: drives PS/2 frames into a hold-mode and a latch-mode instance
// and compares them against a keyboard/direction model kept at the level of keys and events.
module tb_ps2_direction_rx;
  localparam int NP = 2;
  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int W  = 26;  // {brk, ext, code[7:0], dirs_hold[7:0], dirs_latch[7:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic [36*NP-1:0] keymap;

  logic [7:0]    code_h, code_l;
  logic          sv_h, sv_l, brk_h, brk_l, ext_h, ext_l, fe_h, fe_l;
  logic [NP-1:0] l_h, r_h, u_h, d_h, l_l, r_l, u_l, d_l;
  logic [7:0]    dirs_h, dirs_l;

  assign dirs_h = {d_h, u_h, r_h, l_h};
  assign dirs_l = {d_l, u_l, r_l, l_l};

  always #5 clk = ~clk;

  ps2_direction_rx #(.NUM_PLAYERS(NP), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .HOLD_MODE(1'b1)) u_dut_hold (
    .clk(clk), .rst_n(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .keymap(keymap),
    .scan_code(code_h), .scan_valid(sv_h), .scan_break(brk_h), .scan_ext(ext_h), .frame_err(fe_h),
    .dir_left(l_h), .dir_right(r_h), .dir_up(u_h), .dir_down(d_h)
  );

  ps2_direction_rx #(.NUM_PLAYERS(NP), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .HOLD_MODE(1'b0)) u_dut_latch (
    .clk(clk), .rst_n(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .keymap(keymap),
    .scan_code(code_l), .scan_valid(sv_l), .scan_break(brk_l), .scan_ext(ext_l), .frame_err(fe_l),
    .dir_left(l_l), .dir_right(r_l), .dir_up(u_l), .dir_down(d_l)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend;
  bit   dir_pending;
  int   ferr_exp = 0;
  int   ferr_seen_h = 0;
  int   ferr_seen_l = 0;

  logic [8:0] km [NP][4];
  bit         pressed [NP][4];
  int         last_k [NP];
  bit         latched [NP][4];
  bit         ext_f, brk_f;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] dirs_now(input bit hold);
    logic [7:0] v;
    v = '0;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 4; k++)
        v[k*NP + p] = hold ? (pressed[p][last_k[p]] && last_k[p] == k) : latched[p][k];
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    bit found;
    if (b == 8'hE0) ext_f = 1'b1;
    else if (b == 8'hF0) brk_f = 1'b1;
    else begin
      for (int p = 0; p < NP; p++) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && km[p][k] == {ext_f, b}) begin
            found = 1'b1;
            if (brk_f) pressed[p][k] = 1'b0;
            else begin
              pressed[p][k] = 1'b1;
              last_k[p] = k;
              for (int j = 0; j < 4; j++) latched[p][j] = (j == k);
            end
          end
        end
      end
      exp_q.push_back({brk_f, ext_f, b, dirs_now(1'b1), dirs_now(1'b0)});
      ext_f = 1'b0;
      brk_f = 1'b0;
    end
  endtask

  task automatic model_err();
    ferr_exp++;
    ext_f = 1'b0;
    brk_f = 1'b0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      last_k[p] = 0;
      for (int k = 0; k < 4; k++) begin
        pressed[p][k] = 1'b0;
        latched[p][k] = 1'b0;
      end
    end
    ext_f = 1'b0;
    brk_f = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_keymap();
    keymap = {km[1][0], km[1][1], km[1][2], km[1][3], km[0][0], km[0][1], km[0][2], km[0][3]};
  endtask

  // ---------------- drivers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    wait_clks($urandom_range(8, 12));
    ps2_clk = 1'b0;
    wait_clks($urandom_range(16, 24));
    ps2_clk = 1'b1;
    wait_clks($urandom_range(8, 12));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic par;
    par = (~^b) ^ bad_par;
    if (bad_par) model_err();
    else model_byte(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      ps2_bit(b[i]);
      if (glitch && i == 3) begin
        ps2_clk = 1'b0;
        wait_clks(FL - 2);
        ps2_clk = 1'b1;
        wait_clks(12);
      end
    end
    ps2_bit(par);
    ps2_bit(1'b1);
    wait_clks(30);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    check_eq({tag, "_ferr_h"}, ferr_seen_h, ferr_exp);
    check_eq({tag, "_ferr_l"}, ferr_seen_l, ferr_exp);
    check_eq({tag, "_dirs_h"}, dirs_h, dirs_now(1'b1));
    check_eq({tag, "_dirs_l"}, dirs_l, dirs_now(1'b0));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      dir_pending = 1'b0;
    end else begin
      if (dir_pending) begin
        check_eq("dir_after_scan_h", dirs_h, pend[15:8]);
        check_eq("dir_after_scan_l", dirs_l, pend[7:0]);
        dir_pending = 1'b0;
      end
      if (fe_h) ferr_seen_h++;
      if (fe_l) ferr_seen_l++;
      if (sv_h || sv_l) begin
        check_eq("scan_valid_pair", sv_l, sv_h);
        check_eq("scan_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          pend = exp_q.pop_front();
          check_eq("scan_h", {brk_h, ext_h, code_h}, pend[25:16]);
          check_eq("scan_l", {brk_l, ext_l, code_l}, pend[25:16]);
          dir_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not complete within cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pool [11] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h6B, 8'h74, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hF0};
    logic [7:0] b;
    int idx;

    km[0][0] = {1'b0, 8'h1C}; km[0][1] = {1'b0, 8'h23}; km[0][2] = {1'b0, 8'h1D}; km[0][3] = {1'b0, 8'h1B};
    km[1][0] = {1'b1, 8'h6B}; km[1][1] = {1'b1, 8'h74}; km[1][2] = {1'b1, 8'h75}; km[1][3] = {1'b1, 8'h72};
    apply_keymap();
    model_reset();

    rst_n = 1'b0;
    wait_clks(5);
    @(negedge clk);
    check_eq("reset_outs_h", {sv_h, brk_h, ext_h, fe_h, code_h, dirs_h}, 0);
    check_eq("reset_outs_l", {sv_l, brk_l, ext_l, fe_l, code_l, dirs_l}, 0);
    rst_n = 1'b1;
    wait_clks(40);

    // 1: plain make of p0 LEFT
    send_frame(8'h1C, 1'b0, 1'b0);
    check_eq("t1_code", code_h, 8'h1C);
    check_eq("t1_brk_ext", {brk_h, ext_h}, 2'b00);
    check_eq("t1_left0_h", l_h[0], 1'b1);
    check_eq("t1_left0_l", l_l[0], 1'b1);
    check_state("t1");

    // 2: break of p0 LEFT
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_eq("t2_brk", brk_h, 1'b1);
    check_eq("t2_left0_h", l_h[0], 1'b0);
    check_eq("t2_left0_l", l_l[0], 1'b1);
    check_state("t2");

    // 3: extended key for p1, unextended code does not match, lone E0 publishes nothing
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check_eq("t3_ext", ext_h, 1'b1);
    check_eq("t3_up1_h", u_h[1], 1'b1);
    send_frame(8'h75, 1'b0, 1'b0);
    check_eq("t3_plain_ext", ext_h, 1'b0);
    check_eq("t3_up1_hold", u_h[1], 1'b1);
    send_frame(8'hE0, 1'b0, 1'b0);
    check_eq("t3_lone_e0_code", {ext_h, code_h}, {1'b0, 8'h75});
    check_state("t3");

    // 4: parity error discards the pending E0
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check_eq("t4_ext", ext_h, 1'b0);
    check_state("t4");

    // 5: mid-frame timeout, then a clean byte
    model_err();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
    wait_clks(TO + 100);
    send_frame(8'h23, 1'b0, 1'b0);
    check_eq("t5_code", code_h, 8'h23);
    check_eq("t5_right0_h", r_h[0], 1'b1);
    check_state("t5");

    // 6: short clock glitch mid-frame must not be sampled
    send_frame(8'h1D, 1'b0, 1'b1);
    check_eq("t6_code", code_h, 8'h1D);
    check_eq("t6_up0_h", u_h[0], 1'b1);
    check_eq("t6_right0_h", r_h[0], 1'b0);
    check_state("t6");

    // reset in the middle of a frame
    send_frame(8'h1C, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs_h", {sv_h, brk_h, ext_h, fe_h, code_h, dirs_h}, 0);
    check_eq("midrst_outs_l", {sv_l, brk_l, ext_l, fe_l, code_l, dirs_l}, 0);
    model_reset();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(40);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_eq("postrst_code", code_h, 8'h1C);
    check_state("postrst");

    // random traffic with overlapping keymap entries
    km[1][1] = {1'b0, 8'h1C};
    km[1][2] = {1'b0, 8'h1C};
    apply_keymap();
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 11);
      if (idx == 11) b = 8'($urandom_range(0, 255));
      else b = pool[idx];
      send_frame(b, $urandom_range(0, 9) == 0, 1'b0);
      if (n % 10 == 9) check_state("rand");
    end
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
